// File: rtl/lsu_mem_port.sv
// Load/store memory port: one valid/ready bus transaction per request, with byte lanes,
// load extension and a bus watchdog. Define LSU_MISALIGN_EXC_EN to trap misaligned accesses.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;
    logic [31:0] wd_cnt_reg;

    logic        illegal_next;
    logic        misalign_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data_next;
    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    // A zero limit disables the watchdog entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        illegal_next = req_we ? (req_funct3 >= 3'b011)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misalign_next = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        case (req_funct3[1:0])
            2'b01:   misalign_next = req_addr[0];
            2'b10:   misalign_next = |req_addr[1:0];
            default: misalign_next = 1'b0;
        endcase
`endif
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = req_wdata;
            end
        endcase
        if (!req_we) begin
            be_next    = 4'b1111;
            wdata_next = '0;
        end
    end

    always_comb begin
        byte_sel = rd_byte[addr_lo_reg];
        half_sel = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data_next = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data_next = {24'd0, byte_sel};
            3'b001:  load_data_next = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data_next = {16'd0, half_sel};
            default: load_data_next = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg   <= IDLE;
            funct3_reg  <= '0;
            addr_lo_reg <= '0;
            wd_cnt_reg  <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_rd     <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg  <= req_funct3;
                        addr_lo_reg <= req_addr[1:0];
                        resp_rd     <= req_rd;
                        resp_rdata  <= '0;
                        resp_err    <= 1'b0;
                        wd_cnt_reg  <= '0;
                        if (illegal_next || misalign_next) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state_reg  <= RESP;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= wdata_next;
                            mem_be    <= be_next;
                            state_reg <= BUS;
                        end
                    end
                end
                BUS: begin
                    // A completing mem_ready takes priority over an expiring watchdog.
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? 32'd0 : load_data_next;
                        resp_err   <= 1'b0;
                        state_reg  <= RESP;
                    end else if (timeout_hit) begin
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        state_reg  <= RESP;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 32'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    mem_valid  <= 1'b0;
                    resp_valid <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a driver issues requests and answers the bus, while a
// monitor pops expected responses from a queue and compares each resp_valid pulse.
module tb_lsu_mem_port;
    localparam int unsigned T_OUT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        busy;

    lsu_mem_port #(.TIMEOUT_CYCLES(T_OUT)) dut (
        .CLK(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int unsigned at;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got rd=%0d rdata=0x%08h err=%0b, expected none",
                         resp_rd, resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                $display("resp rd=%0d rdata=0x%08h err=%0b cycle=%0d", resp_rd, resp_rdata,
                         resp_err, cyc);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_rd", 32'(resp_rd), 32'(e.rd));
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    // mode 0: bus completes after dly low-ready cycles; 1: watchdog expiry; 2: no bus cycle
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int mode,
                          input int dly, input logic [31:0] rdata_in,
                          input logic [31:0] x_addr, input logic [31:0] x_wdata,
                          input logic [3:0] x_be, input logic [31:0] x_rdata, input logic x_err);
        int unsigned a;
        int k;
        bit done;
        exp_t e;
        wait_ready();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b0;
        e.rdata = x_rdata;
        e.rd    = rd;
        e.err   = x_err;
        e.at    = (mode == 2) ? a : ((mode == 1) ? a + T_OUT : a + 32'(dly) + 1);
        exp_q.push_back(e);
        if (mode == 2) begin
            @(negedge clk);
            chk("no_bus_valid", 32'(mem_valid), 32'd0);
        end else begin
            k = 0;
            done = 1'b0;
            while (!done && k < 64) begin
                @(negedge clk);
                k++;
                if (mode == 1 && k == T_OUT + 1) begin
                    chk("timeout_drop", 32'(mem_valid), 32'd0);
                    done = 1'b1;
                end else begin
                    chk("mem_valid", 32'(mem_valid), 32'd1);
                    chk("mem_we", 32'(mem_we), 32'(we));
                    chk("mem_addr", mem_addr, x_addr);
                    chk("mem_wdata", mem_wdata, x_wdata);
                    chk("mem_be", 32'(mem_be), 32'(x_be));
                    chk("busy", 32'(busy), 32'd1);
                    mem_rdata = rdata_in;
                    if (mode == 0 && k > dly) begin
                        mem_ready = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus_bound: got no completion in 64 cycles, expected completion");
            end
            if (mode == 0) begin
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;

        // we, f3, addr, wdata, rd, mode, dly, rdata_in, x_addr, x_wdata, x_be, x_rdata, x_err
        do_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd3, 0, 0, 32'h0,
               32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0, 1'b0);
        do_req(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h0000_8000,
               32'h0000_2000, 32'h0, 4'b1111, 32'hFFFF_FF80, 1'b0);
        do_req(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd6, 0, 0, 32'h0000_8000,
               32'h0000_2000, 32'h0, 4'b1111, 32'h0000_0080, 1'b0);
        do_req(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd7, 0, 5, 32'h8001_0000,
               32'h0000_2000, 32'h0, 4'b1111, 32'hFFFF_8001, 1'b0);
        do_req(1'b0, 3'b101, 32'h0000_2000, 32'h0, 5'd8, 0, 1, 32'h1234_F00D,
               32'h0000_2000, 32'h0, 4'b1111, 32'h0000_F00D, 1'b0);
        do_req(1'b1, 3'b001, 32'h0000_4002, 32'hDEAD_BEEF, 5'd9, 0, 2, 32'h0,
               32'h0000_4000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 1'b0);
        do_req(1'b1, 3'b010, 32'h0000_5000, 32'h0123_4567, 5'd10, 0, 0, 32'h0,
               32'h0000_5000, 32'h0123_4567, 4'b1111, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h0000_6004, 32'h0, 5'd11, 0, 0, 32'hCAFE_BABE,
               32'h0000_6004, 32'h0, 4'b1111, 32'hCAFE_BABE, 1'b0);
        do_req(1'b0, 3'b000, 32'h0000_7002, 32'h0, 5'd12, 0, 0, 32'h007F_0000,
               32'h0000_7000, 32'h0, 4'b1111, 32'h0000_007F, 1'b0);
        do_req(1'b1, 3'b000, 32'h0000_1001, 32'h0000_003C, 5'd13, 0, 0, 32'h0,
               32'h0000_1000, 32'h3C3C_3C3C, 4'b0010, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd14, 1, 0, 32'h0,
               32'h0000_8000, 32'h0, 4'b1111, 32'h0, 1'b1);
        do_req(1'b0, 3'b011, 32'h0000_9000, 32'h0, 5'd15, 2, 0, 32'h0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
        do_req(1'b0, 3'b110, 32'h0000_9000, 32'h0, 5'd16, 2, 0, 32'h0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
        do_req(1'b1, 3'b011, 32'h0000_9000, 32'h1, 5'd17, 2, 0, 32'h0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
        do_req(1'b1, 3'b111, 32'h0000_9000, 32'h1, 5'd18, 2, 0, 32'h0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_EXC_EN
        do_req(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd19, 2, 0, 32'h0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
        do_req(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd19, 0, 0, 32'h1122_3344,
               32'h0000_3000, 32'h0, 4'b1111, 32'h1122_3344, 1'b0);
`endif

        // Reset asserted while the bus is waiting: no response may follow.
        wait_ready();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_A000;
        req_rd     = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        do_req(1'b0, 3'b001, 32'h0000_B002, 32'h0, 5'd21, 0, 0, 32'h7FFF_0000,
               32'h0000_B000, 32'h0, 4'b1111, 32'h0000_7FFF, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
